// File: rtl/mips_pkg.sv
// Core-wide shared definitions for the MIPS datapath: default widths, the
// hardwired-zero register index and the register-file clear state type.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per register, set by issue-time
// claims and cleared by retiring writes, with combinational lookup per read port.
module rf_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ca,
  input  logic              ce,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             retire, claim;
  logic             fwd1, fwd2;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    retire = active && we3 && (a3 != ZERO_ADDR);
    claim  = active && ce && (ca != ZERO_ADDR);
    busy_d = busy_q;
    if (retire) busy_d[a3] = 1'b0;
    // Claim applied last: a newly issued producer outranks a same-cycle retire.
    if (claim) busy_d[ca] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  function automatic logic busy_lookup(input logic [ADDR_W-1:0] addr,
                                       input logic              act,
                                       input logic              fwd,
                                       input logic [DEPTH-1:0]  vec);
    if (!act || addr == ZERO_ADDR) return 1'b0;
    if (fwd) return 1'b0;
    return vec[addr];
  endfunction

  always_comb begin
    fwd1  = BYPASS && we3 && (a3 == a1);
    fwd2  = BYPASS && we3 && (a3 == a2);
    busy1 = busy_lookup(a1, active, fwd1, busy_q);
    busy2 = busy_lookup(a2, active, fwd2, busy_q);
  end

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file (2 read / 1 write, r0 hardwired to zero) with a
// post-reset sequential clear, optional write-first bypass and busy scoreboard.
module reg_file_sb
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] CA,
  input  logic              CE,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              active;

  assign active = (state_q == READY);
  assign ready  = active;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_waddr = A3;
    mem_wdata = WD3;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = '0;
        idx_d     = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) state_d = READY;
      end
      READY: mem_we = WE3 && (A3 != ZERO_ADDR);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: storage has no reset branch; the CLEAR walk zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] addr,
                                                 input logic              act,
                                                 input logic [DATA_W-1:0] stored);
    if (!act || addr == ZERO_ADDR) return '0;
    if (BYPASS && WE3 && A3 == addr) return WD3;
    return stored;
  endfunction

  always_comb begin
    RD1 = read_sel(A1, active, mem_q[A1]);
    RD2 = read_sel(A2, active, mem_q[A2]);
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) u_scoreboard (
    .clk   (clk),
    .reset (reset),
    .active(active),
    .a1    (A1),
    .a2    (A2),
    .a3    (A3),
    .we3   (WE3),
    .ca    (CA),
    .ce    (CE),
    .busy1 (busy1),
    .busy2 (busy2)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypass and a non-bypass instance share
// stimulus; per-cycle vectors plus hand sequences for clear and reset.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2, a3, ca;
  logic [31:0] wd3;
  logic        we3, ce;

  logic        ready_b, ready_n;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .ready(ready_b),
    .A1(a1), .A2(a2), .RD1(rd1_b), .RD2(rd2_b),
    .A3(a3), .WD3(wd3), .WE3(we3), .CA(ca), .CE(ce),
    .busy1(busy1_b), .busy2(busy2_b)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .ready(ready_n),
    .A1(a1), .A2(a2), .RD1(rd1_n), .RD2(rd2_n),
    .A3(a3), .WD3(wd3), .WE3(we3), .CA(ca), .CE(ce),
    .busy1(busy1_n), .busy2(busy2_n)
  );

  typedef struct {
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] b_rd1, b_rd2;
    logic        b_busy1, b_busy2;
    logic [31:0] n_rd1, n_rd2;
    logic        n_busy1, n_busy2;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; a3 = '0; wd3 = '0; ce = 1'b0; ca = '0; a1 = '0; a2 = '0;
  endtask

  task automatic add(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic c, input logic [4:0] cadr,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] brd1, input logic [31:0] brd2,
                     input logic bb1, input logic bb2,
                     input logic [31:0] nrd1, input logic [31:0] nrd2,
                     input logic nb1, input logic nb2);
    vec_t v;
    v = '{w, wa, wd, c, cadr, r1, r2, brd1, brd2, bb1, bb2, nrd1, nrd2, nb1, nb2};
    vecs.push_back(v);
  endtask

  // Waits n edges after reset release, checking ready rises exactly on edge 32.
  task automatic clear_walk(input string tag);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (k == 31) check({tag, " ready before edge 32"}, 32'(ready_b), 32'd0);
      if (k == 32) begin
        check({tag, " ready at edge 32"}, 32'(ready_b), 32'd1);
        check({tag, " ready_nb at edge 32"}, 32'(ready_n), 32'd1);
      end
    end
  endtask

  initial begin
    // Each row is one cycle; expectations are the combinational outputs seen
    // during that cycle, before its closing edge.
    //   we3 a3 wd3            ce ca a1 a2 | bypass rd1, rd2, b1, b2 | no-bypass rd1, rd2, b1, b2
    add(1, 7, 32'h12345678, 0, 0, 7, 0,  32'h12345678, 0, 0, 0,  32'h0, 0, 0, 0);
    add(1, 0, 32'hFFFFFFFF, 0, 0, 7, 0,  32'h12345678, 0, 0, 0,  32'h12345678, 0, 0, 0);
    add(0, 0, 32'h0,        0, 0, 7, 0,  32'h12345678, 0, 0, 0,  32'h12345678, 0, 0, 0);
    add(1, 9, 32'hCAFEF00D, 0, 0, 9, 7,  32'hCAFEF00D, 32'h12345678, 0, 0,  32'h0, 32'h12345678, 0, 0);
    add(1, 9, 32'h11112222, 0, 0, 9, 9,  32'h11112222, 32'h11112222, 0, 0,  32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    add(0, 0, 32'h0,        1, 4, 4, 9,  32'h0, 32'h11112222, 0, 0,  32'h0, 32'h11112222, 0, 0);
    add(0, 0, 32'h0,        0, 0, 4, 0,  32'h0, 32'h0, 1, 0,  32'h0, 32'h0, 1, 0);
    add(1, 4, 32'h44,       0, 0, 4, 4,  32'h44, 32'h44, 0, 0,  32'h0, 32'h0, 1, 1);
    add(0, 0, 32'h0,        0, 0, 4, 0,  32'h44, 32'h0, 0, 0,  32'h44, 32'h0, 0, 0);
    add(0, 0, 32'h0,        1, 0, 0, 4,  32'h0, 32'h44, 0, 0,  32'h0, 32'h44, 0, 0);
    add(0, 0, 32'h0,        0, 0, 0, 4,  32'h0, 32'h44, 0, 0,  32'h0, 32'h44, 0, 0);
    add(0, 0, 32'h0,        1, 6, 6, 6,  32'h0, 32'h0, 0, 0,  32'h0, 32'h0, 0, 0);
    add(1, 6, 32'h55,       1, 6, 6, 6,  32'h55, 32'h55, 0, 0,  32'h0, 32'h0, 1, 1);
    add(0, 0, 32'h0,        0, 0, 6, 4,  32'h55, 32'h44, 1, 0,  32'h55, 32'h44, 1, 0);
    add(0, 0, 32'h0,        1, 6, 6, 0,  32'h55, 32'h0, 1, 0,  32'h55, 32'h0, 1, 0);
    add(0, 0, 32'h0,        0, 0, 6, 7,  32'h55, 32'h12345678, 1, 0,  32'h55, 32'h12345678, 1, 0);
    add(1, 6, 32'h66,       0, 0, 6, 6,  32'h66, 32'h66, 0, 0,  32'h55, 32'h55, 1, 1);
    add(0, 0, 32'h0,        0, 0, 6, 9,  32'h66, 32'h11112222, 0, 0,  32'h66, 32'h11112222, 0, 0);

    // Reset held three cycles.
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(ready_b), 32'd0);
    check("reset rd1", rd1_b, 32'h0);
    check("reset busy1", 32'(busy1_b), 32'd0);

    // Clear walk with writes attempted to r5; they must be ignored.
    reset = 1'b0;
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD; a1 = 5'd5;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (k < 32) begin
        check($sformatf("clear ready edge%0d", k), 32'(ready_b), 32'd0);
        if (k == 10) check("clear rd1 gated", rd1_b, 32'h0);
      end else begin
        check("clear ready edge32", 32'(ready_b), 32'd1);
      end
    end
    idle_inputs();
    a1 = 5'd5;
    #1;
    check("clear r5 stays zero", rd1_b, 32'h0);
    check("clear r5 not busy", 32'(busy1_b), 32'd0);

    // Vector table, both instances in lockstep.
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      we3 = vecs[i].we3; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
      ce  = vecs[i].ce;  ca = vecs[i].ca; a1 = vecs[i].a1; a2 = vecs[i].a2;
      #2;
      check($sformatf("row%0d rd1", i), rd1_b, vecs[i].b_rd1);
      check($sformatf("row%0d rd2", i), rd2_b, vecs[i].b_rd2);
      check($sformatf("row%0d busy1", i), 32'(busy1_b), 32'(vecs[i].b_busy1));
      check($sformatf("row%0d busy2", i), 32'(busy2_b), 32'(vecs[i].b_busy2));
      check($sformatf("row%0d nb rd1", i), rd1_n, vecs[i].n_rd1);
      check($sformatf("row%0d nb rd2", i), rd2_n, vecs[i].n_rd2);
      check($sformatf("row%0d nb busy1", i), 32'(busy1_n), 32'(vecs[i].n_busy1));
      check($sformatf("row%0d nb busy2", i), 32'(busy2_n), 32'(vecs[i].n_busy2));
      @(posedge clk); #1;
    end

    // Mid-operation reset: r3 written and claimed, then one reset cycle.
    idle_inputs();
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'hFF;
    @(posedge clk); #1;
    idle_inputs();
    ce = 1'b1; ca = 5'd3;
    @(posedge clk); #1;
    idle_inputs();
    a2 = 5'd3;
    #1;
    check("pre-reset r3 data", rd2_b, 32'hFF);
    check("pre-reset r3 busy", 32'(busy2_b), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid reset ready", 32'(ready_b), 32'd0);
    check("mid reset busy2", 32'(busy2_b), 32'd0);
    check("mid reset rd2", rd2_b, 32'h0);
    reset = 1'b0;

    // Reset again partway through the clear; the walk must restart from scratch.
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_walk("restart");
    #1;
    check("post-clear r3 data", rd2_b, 32'h0);
    check("post-clear r3 busy", 32'(busy2_b), 32'd0);
    check("post-clear r3 data nb", rd2_n, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
